uart_rx_core: RTL

- Serial UART receiver, 8N1 by default, oversampled by the system clock.
- Sits directly upstream of the UART internal write FSM.
- Converts the asynchronous RX pin into a byte plus a single-cycle o_rx_valid strobe, which the write FSM consumes to latch the byte and write the FIFO.
- Flags framing errors and holds off re-arming while the line is held low (break).

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_rx_core.sv | 122 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud constant and frame-format defaults.
package uart_pkg;

    localparam int CLKS_PER_BIT_115200 = 868;
    localparam int DATA_BITS_DEFAULT   = 8;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        STOP       = 3'd3,
        BREAK_WAIT = 3'd4
    } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; reset value is a parameter
// so idle-high lines such as a UART RX pin do not fake an edge out of reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// Oversampled UART receiver: start-bit glitch rejection, mid-bit sampling, framing-error
// flag and break hold-off. Emits one-cycle valid / error strobes to the write FSM.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int DATA_BITS    = DATA_BITS_DEFAULT
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx_serial,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF     = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_LAST = IW'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_e            state_q;
    logic [CW-1:0]        cnt_q;
    logic [IW-1:0]        bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 done_q;
    logic                 stop_bit_q;
    logic                 valid_q;
    logic                 err_q;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_rx_sync (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_d  (i_rx_serial),
        .o_q  (rx_s)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            stop_bit_q <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // Stop-bit verdict is registered once, then published the following cycle.
            valid_q <= done_q & stop_bit_q;
            err_q   <= done_q & ~stop_bit_q;
            done_q  <= 1'b0;
            if (done_q && stop_bit_q) begin
                data_q <= shift_q;
            end

            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    if (cnt_q == HALF) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == LAST) begin
                        cnt_q              <= '0;
                        shift_q[bit_idx_q] <= rx_s;
                        if (bit_idx_q == BIT_LAST) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == LAST) begin
                        cnt_q      <= '0;
                        done_q     <= 1'b1;
                        stop_bit_q <= rx_s;
                        state_q    <= rx_s ? IDLE : BREAK_WAIT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                BREAK_WAIT: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    bit_idx_q <= '0;
                end
            endcase
        end
    end

    assign o_rx_data   = data_q;
    assign o_rx_valid  = valid_q;
    assign o_frame_err = err_q;
    assign o_busy      = (state_q != IDLE);

endmodule
